// File: rtl/nios2_sysid_pkg.sv
// Shared definitions for the system-ID register block: register offsets,
// CTRL bit positions and the capability word layout.
package nios2_sysid_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    typedef enum logic [ADDR_W-1:0] {
        REG_ID        = 4'd0,
        REG_TIMESTAMP = 4'd1,
        REG_UPTIME_LO = 4'd2,
        REG_UPTIME_HI = 4'd3,
        REG_CTRL      = 4'd4,
        REG_CAPS      = 4'd5
    } reg_addr_e;

    localparam logic [ADDR_W-1:0] SCRATCH_BASE = 4'd8;

    localparam logic [15:0] CAPS_VERSION = 16'h0002;

    localparam int CTRL_FREEZE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    // CAPS: [3:0] scratch word count, [14:8] uptime width, [31:16] version.
    function automatic logic [DATA_W-1:0] caps_word(input logic [3:0] num_scratch,
                                                   input logic [6:0] uptime_w);
        logic [DATA_W-1:0] w;
        w        = '0;
        w[3:0]   = num_scratch;
        w[14:8]  = uptime_w;
        w[31:16] = CAPS_VERSION;
        return w;
    endfunction

endpackage

// File: rtl/nios2_sysid_regs_if.sv
// Avalon-MM slave bus bundle for the system-ID register block
// (fixed read latency 1, no waitrequest).
interface nios2_sysid_regs_if;
    import nios2_sysid_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [3:0]        byteenable;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/nios2_sysid_uptime.sv
// Free-running uptime counter with freeze and a synchronous clear that
// overrides both counting and freeze. Wraps naturally at 2^UPTIME_W.
module nios2_sysid_uptime #(
    parameter int UPTIME_W = 48
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                freeze,
    input  logic                clear,
    output logic [UPTIME_W-1:0] count
);

    logic [UPTIME_W-1:0] count_q;

    // Count every clock unless frozen; clear has priority over everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (!freeze) begin
            count_q <= count_q + UPTIME_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/nios2_sysid_regs.sv
// System-ID / uptime / scratch register block on an Avalon-MM slave.
// Reads are registered (latency 1); a simultaneous write returns the
// pre-write value because the read mux samples state before the edge.
module nios2_sysid_regs
    import nios2_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'd1457621591,
    parameter int          NUM_SCRATCH = 2,
    parameter int          UPTIME_W    = 48
) (
    input  logic                clock,
    input  logic                reset_n,
    nios2_sysid_regs_if.slave   bus
);

    localparam int HI_W = UPTIME_W - 32;
    localparam logic [DATA_W-1:0] CAPS_VALUE = caps_word(4'(NUM_SCRATCH), 7'(UPTIME_W));

    logic [UPTIME_W-1:0] count;
    logic [HI_W-1:0]     shadow;
    logic                ctrl_freeze;
    logic                ctrl_wr;
    logic                ctrl_clear;
    logic [DATA_W-1:0]   scratch [NUM_SCRATCH];
    logic [DATA_W-1:0]   scratch_rd;
    logic [DATA_W-1:0]   rd_data_p0;

    assign ctrl_wr    = bus.write && (bus.address == REG_CTRL);
    assign ctrl_clear = ctrl_wr && bus.writedata[CTRL_CLEAR_BIT];

    nios2_sysid_uptime #(
        .UPTIME_W (UPTIME_W)
    ) u_uptime (
        .clock   (clock),
        .reset_n (reset_n),
        .freeze  (ctrl_freeze),
        .clear   (ctrl_clear),
        .count   (count)
    );

    // CTRL.freeze is the only stored CTRL bit; clear is a pure strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_freeze <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_freeze <= bus.writedata[CTRL_FREEZE_BIT];
        end
    end

    // Latch the counter's upper bits whenever the low word is read, so a
    // LO-then-HI read pair is coherent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (bus.read && (bus.address == REG_UPTIME_LO)) begin
            shadow <= count[UPTIME_W-1:32];
        end
    end

    // Byte-lane writes into the scratch words that actually exist.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= '0;
            end
        end else if (bus.write) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (bus.address == SCRATCH_BASE + 4'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.byteenable[b]) begin
                            scratch[i][8*b +: 8] <= bus.writedata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Scratch read select; absent words fall through as zero.
    always_comb begin
        scratch_rd = '0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (bus.address == SCRATCH_BASE + 4'(i)) begin
                scratch_rd = scratch[i];
            end
        end
    end

    // Read mux over the pre-edge register state.
    always_comb begin
        rd_data_p0 = '0;
        case (bus.address)
            REG_ID:        rd_data_p0 = SYSTEM_ID;
            REG_TIMESTAMP: rd_data_p0 = TIMESTAMP;
            REG_UPTIME_LO: rd_data_p0 = count[31:0];
            REG_UPTIME_HI: rd_data_p0[HI_W-1:0] = shadow;
            REG_CTRL:      rd_data_p0[CTRL_FREEZE_BIT] = ctrl_freeze;
            REG_CAPS:      rd_data_p0 = CAPS_VALUE;
            default:       rd_data_p0 = scratch_rd;
        endcase
    end

    // ---- stage p0 -> p1: registered read response, zero when not valid ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= bus.read;
            bus.readdata      <= bus.read ? rd_data_p0 : '0;
        end
    end

endmodule

// File: tb/tb_nios2_sysid_regs.sv
// Directed bench for nios2_sysid_regs with default parameters.
module tb_nios2_sysid_regs;

    localparam logic [31:0] TS_EXP   = 32'd1457621591;
    localparam logic [31:0] CAPS_EXP = 32'h0002_3002;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    nios2_sysid_regs_if bus();

    nios2_sysid_regs dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.address    = '0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = '0;
    endtask

    // Called at a falling edge; presents one access for one cycle,
    // captures the response just after the rising edge, returns at the next falling edge.
    task automatic do_access(input logic [3:0] addr, input logic rd, input logic wr,
                             input logic [31:0] wd, input logic [3:0] be,
                             output logic [31:0] rdata, output logic rvalid);
        bus.address    = addr;
        bus.read       = rd;
        bus.write      = wr;
        bus.writedata  = wd;
        bus.byteenable = be;
        @(posedge clock);
        #1;
        rdata  = bus.readdata;
        rvalid = bus.readdatavalid;
        bus_idle();
        @(negedge clock);
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] d;
        logic        v;
        do_access(addr, 1'b0, 1'b1, wd, be, d, v);
    endtask

    task automatic do_read(input logic [3:0] addr, output logic [31:0] d);
        logic v;
        do_access(addr, 1'b1, 1'b0, '0, '0, d, v);
        check("read_vld", {63'd0, v}, 64'd1);
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        do_read(addr, d);
        check(tag, {32'd0, d}, {32'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, d;
        logic        v;

        bus_idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_rdata", {32'd0, bus.readdata}, 64'd0);
        check("rst_rdv", {63'd0, bus.readdatavalid}, 64'd0);
        reset_n = 1'b1;

        // Back-to-back reads of ID, TIMESTAMP, CAPS
        bus.read    = 1'b1;
        bus.address = 4'd0;
        @(posedge clock); #1;
        check("b2b_id_vld", {63'd0, bus.readdatavalid}, 64'd1);
        check("b2b_id", {32'd0, bus.readdata}, 64'd0);
        bus.address = 4'd1;
        @(posedge clock); #1;
        check("b2b_ts_vld", {63'd0, bus.readdatavalid}, 64'd1);
        check("b2b_ts", {32'd0, bus.readdata}, {32'd0, TS_EXP});
        bus.address = 4'd5;
        @(posedge clock); #1;
        check("b2b_caps_vld", {63'd0, bus.readdatavalid}, 64'd1);
        check("b2b_caps", {32'd0, bus.readdata}, {32'd0, CAPS_EXP});
        bus_idle();
        @(posedge clock); #1;
        check("idle_rdv", {63'd0, bus.readdatavalid}, 64'd0);
        check("idle_rdata", {32'd0, bus.readdata}, 64'd0);
        @(negedge clock);

        // Unmapped addresses
        read_check("unmapped6", 4'd6, 32'd0);
        read_check("unmapped15", 4'd15, 32'd0);
        do_write(4'd10, 32'h1234_5678, 4'hF);
        read_check("scr10", 4'd10, 32'd0);

        // Scratch byte lanes
        do_write(4'd8, 32'hDEAD_BEEF, 4'hF);
        read_check("scr8_full", 4'd8, 32'hDEAD_BEEF);
        do_write(4'd8, 32'h0000_5500, 4'b0010);
        read_check("scr8_be", 4'd8, 32'hDEAD_55EF);

        // Read and write in the same cycle returns old contents
        do_access(4'd9, 1'b1, 1'b1, 32'h1122_3344, 4'hF, d, v);
        check("rdw_vld", {63'd0, v}, 64'd1);
        check("rdw_old", {32'd0, d}, 64'd0);
        read_check("rdw_new", 4'd9, 32'h1122_3344);

        // Freeze holds the counter
        do_write(4'd4, 32'd1, 4'hF);
        read_check("ctrl_frz", 4'd4, 32'd1);
        do_read(4'd2, a);
        repeat (4) @(negedge clock);
        do_read(4'd2, b);
        check("frz_equal", {32'd0, b}, {32'd0, a});

        // Unfreeze: reads 5 cycles apart differ by 5
        do_write(4'd4, 32'd0, 4'hF);
        do_read(4'd2, a);
        repeat (4) @(negedge clock);
        do_read(4'd2, b);
        check("run_delta", {32'd0, b - a}, 64'd5);

        // Clear while running: three edges after the write edge
        do_write(4'd4, 32'd2, 4'hF);
        repeat (3) @(negedge clock);
        read_check("clr_count", 4'd2, 32'd3);
        read_check("ctrl_after_clr", 4'd4, 32'd0);

        // Clear together with freeze: counter zeroed and stays there
        do_write(4'd4, 32'd3, 4'hF);
        repeat (3) @(negedge clock);
        read_check("clr_frozen", 4'd2, 32'd0);
        read_check("ctrl_frz_only", 4'd4, 32'd1);
        do_write(4'd4, 32'd0, 4'hF);

        // Shadow coherence across the 32-bit boundary
        force dut.u_uptime.count_q = 48'h0000_FFFF_FFFF;
        read_check("lo_at_wrap", 4'd2, 32'hFFFF_FFFF);
        force dut.u_uptime.count_q = 48'h0001_0000_0001;
        @(negedge clock);
        read_check("hi_shadow", 4'd3, 32'd0);
        do_read(4'd2, d);
        check("lo_after_wrap", {32'd0, d}, 64'd1);
        read_check("hi_live", 4'd3, 32'd1);
        release dut.u_uptime.count_q;

        // Reset in the middle of a read and a scratch write
        bus.read    = 1'b1;
        bus.address = 4'd1;
        @(posedge clock); #1;
        check("pre_rst_vld", {63'd0, bus.readdatavalid}, 64'd1);
        bus.write      = 1'b1;
        bus.address    = 4'd8;
        bus.writedata  = 32'hCAFE_F00D;
        bus.byteenable = 4'hF;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rdv", {63'd0, bus.readdatavalid}, 64'd0);
        check("async_rdata", {32'd0, bus.readdata}, 64'd0);
        @(posedge clock); #1;
        check("rst_hold_rdv", {63'd0, bus.readdatavalid}, 64'd0);
        bus_idle();
        @(negedge clock);
        reset_n = 1'b1;
        read_check("scr8_after_rst", 4'd8, 32'd0);
        read_check("lo_after_rst", 4'd2, 32'd1);
        read_check("scr9_after_rst", 4'd9, 32'd0);
        read_check("hi_after_rst", 4'd3, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios2_sysid_regs.md
NIOS2_SYSID_REGS -- requirements
Module: nios2_sysid_regs

Interface
REQ-001 SHALL have parameter SYSTEM_ID, default 32'h0000_0000, value returned at ID register.
REQ-002 SHALL have parameter TIMESTAMP, default 32'd1457621591, value returned at TIMESTAMP register.
REQ-003 SHALL have parameter NUM_SCRATCH, default 2, legal 1..8, number of read/write scratch words.
REQ-004 SHALL have parameter UPTIME_W, default 48, legal 33..64, uptime counter width.
REQ-005 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port address, input, 4, Avalon-MM word address.
REQ-008 SHALL have port read, input, 1, read strobe.
REQ-009 SHALL have port write, input, 1, write strobe.
REQ-010 SHALL have port writedata, input, 32, write data.
REQ-011 SHALL have port byteenable, input, 4, byte lanes for writes.
REQ-012 SHALL have port readdata, output, 32, registered read data.
REQ-013 SHALL have port readdatavalid, output, 1, one-cycle pulse qualifying readdata.

Function
REQ-014 SHALL use the following register map: 0 ID (RO); 1 TIMESTAMP (RO); 2 UPTIME_LO (RO); 3 UPTIME_HI (RO); 4 CTRL (RW); 5 CAPS (RO); 8..8+NUM_SCRATCH-1 SCRATCH (RW).
REQ-015 SHALL return 0 on reads of unmapped or unimplemented addresses, with readdatavalid still asserted; writes there are ignored.
REQ-016 SHALL have fixed read latency 1 and no waitrequest: a read in cycle N yields readdatavalid=1 and data in cycle N+1.
REQ-017 SHALL drive readdata to 0 in every cycle where readdatavalid=0.
REQ-018 SHALL accept back-to-back reads every cycle.
REQ-019 SHALL increment the uptime counter by 1 per clock when CTRL.freeze=0, and wrap from 2^UPTIME_W-1 to 0.
REQ-020 SHALL, on a read of UPTIME_LO in cycle N, return counter[31:0] as valued in cycle N, and load the shadow with counter[UPTIME_W-1:32] in the same edge.
REQ-021 SHALL return the zero-extended shadow on UPTIME_HI reads; the shadow changes only on an UPTIME_LO read.
REQ-022 SHALL define CTRL bit0 as freeze (RW) and bit1 as clear (write-1 pulse, reads 0); all other bits read 0.
REQ-023 SHALL zero the counter on the edge ending a write of CTRL with bit1=1; clear wins over increment and freeze; the shadow is unaffected.
REQ-024 SHALL define CAPS as [3:0]=NUM_SCRATCH, [14:8]=UPTIME_W, [31:16]=16'h0002 (version); all other bits 0.
REQ-025 SHALL update each scratch byte only where the corresponding byteenable bit is 1.
REQ-026 SHALL, when read and write are both asserted in a cycle, perform the write and return the pre-write register value.

Reset
REQ-027 SHALL, on reset_n low, immediately set counter, shadow, CTRL, all scratch words, readdata and readdatavalid to 0.
REQ-028 SHALL suppress a read presented in the cycle reset deasserts is not required; a read aborted by reset produces no readdatavalid.

Structure
REQ-029 SHALL place register offsets, CAPS version constant and CTRL bit indices in shared package nios2_sysid_pkg.
REQ-030 SHALL implement the counter, freeze and clear logic in sub-module nios2_sysid_uptime (parameter UPTIME_W).
REQ-031 SHALL elaborate scratch storage from NUM_SCRATCH, with no storage for absent words.

Verification
REQ-032 Reset, then read addr 0,1,5 back-to-back -> readdatavalid on 3 consecutive cycles; data 0, 1457621591, 32'h0002_3002.
REQ-033 Write scratch 8 = 32'hDEADBEEF, then byteenable=4'b0010 data 32'h0000_5500 -> read returns 32'hDEAD55EF; read addr 10 -> 0.
REQ-034 Freeze via CTRL=1, read UPTIME_LO twice 5 cycles apart -> identical values; clear CTRL freeze -> values then differ by cycle count.
REQ-035 Force counter to 48'h0000_FFFF_FFFF: read LO -> 32'hFFFFFFFF; two cycles later read HI -> 0 (shadow, not live value 1).
REQ-036 Write CTRL=2 while running -> next LO read equals the cycle count since the write edge; CTRL readback = 0.
REQ-037 Assert reset_n low mid-read and mid-scratch-write -> all outputs 0 asynchronously; no readdatavalid; scratch reads 0 after release.
